// File: rtl/kara_pkg.sv
// kara_pkg: shared definitions for the Karatsuba split/issue front end.
//   - kara_state_t   : FSM state encoding (IDLE, MUL_HI, MUL_LO, MUL_MID, FORM, HOLD)
//   - KARA_W/KARA_H  : default operand width and derived half width
//   - kara_mid_width : width of the middle-sum product zm (W+2)
package kara_pkg;

  localparam int KARA_W = 32;
  localparam int KARA_H = KARA_W / 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL_HI  = 3'd1,
    ST_MUL_LO  = 3'd2,
    ST_MUL_MID = 3'd3,
    ST_FORM    = 3'd4,
    ST_HOLD    = 3'd5
  } kara_state_t;

  // (H+1)x(H+1) product of the two middle sums needs 2*(W/2+1) = W+2 bits.
  function automatic int kara_mid_width(input int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/karatsuba_split_issue_if.sv
// karatsuba_split_issue_if: operand input handshake and term output handshake
// of the Karatsuba front end.
//   in_valid/in_ready/a/b          : operand pair transfer (producer -> block)
//   out_valid/out_ready/mult1..3   : aligned 2W-bit terms (block -> summing stage)
//   busy                           : block is not idle
// modport slave  : the multiplier front end
// modport master : the agent driving operands and accepting terms
interface karatsuba_split_issue_if
  import kara_pkg::*;
#(
  parameter int W = KARA_W
);

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] mult1;
  logic [2*W-1:0] mult2;
  logic [2*W-1:0] mult3;
  logic           busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, mult1, mult2, mult3, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, mult1, mult2, mult3, busy
  );

endinterface

// File: rtl/kara_half_mul.sv
// kara_half_mul: the single shared unsigned NxN multiplier (N = H+1).
// Build option KARA_MUL_PIPE_EN: when defined, the product is registered
// (one cycle latency) and the module gains clk/rst ports; when undefined the
// product is purely combinational.
// Ports:
//   clk, rst : clock / async active-high reset (KARA_MUL_PIPE_EN only)
//   op_a     : N-bit unsigned operand
//   op_b     : N-bit unsigned operand
//   prod     : 2N-bit unsigned product
module kara_half_mul
  import kara_pkg::*;
#(
  parameter int N = KARA_H + 1
) (
`ifdef KARA_MUL_PIPE_EN
  input  logic           clk,
  input  logic           rst,
`endif
  input  logic [N-1:0]   op_a,
  input  logic [N-1:0]   op_b,
  output logic [2*N-1:0] prod
);

  logic [2*N-1:0] prod_s;

  assign prod_s = op_a * op_b;

`ifdef KARA_MUL_PIPE_EN
  logic [2*N-1:0] prod_r;

  // Output register of the pipelined multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_r <= {(2*N){1'b0}};
    end else begin
      prod_r <= prod_s;
    end
  end

  assign prod = prod_r;
`else
  assign prod = prod_s;
`endif

endmodule

// File: rtl/karatsuba_split_issue.sv
// karatsuba_split_issue: front end of the WxW Karatsuba multiplier.
// Accepts an operand pair, computes z2 = aH*bH, z0 = aL*bL and
// zm = (aH+aL)*(bH+bL) one after another on one shared (H+1)x(H+1)
// multiplier, then issues mult1 = z2<<W, mult2 = (zm-z2-z0)<<H, mult3 = z0.
// mult1+mult2+mult3 equals a*b exactly.
// Build option KARA_MUL_PIPE_EN: registered multiplier, each MUL_* state lasts
// two cycles (phase bit), out_valid rises 7 edges after accept instead of 4.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous reset, active-high
//   bus : karatsuba_split_issue_if.slave (in_valid/in_ready/a/b,
//         out_valid/out_ready/mult1..3, busy)
module karatsuba_split_issue
  import kara_pkg::*;
#(
  parameter int W = KARA_W   // must be even
) (
  input  logic                   clk,
  input  logic                   rst,
  karatsuba_split_issue_if.slave bus
);

  localparam int H  = W / 2;
  localparam int HN = H + 1;
  localparam int MW = kara_mid_width(W);

  kara_state_t    state_r;
  kara_state_t    state_s;

  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [W-1:0]   z2_r;
  logic [W-1:0]   z0_r;
  logic [MW-1:0]  zm_r;
  logic [2*W-1:0] mult1_r;
  logic [2*W-1:0] mult2_r;
  logic [2*W-1:0] mult3_r;
  logic           out_valid_r;

  logic [HN-1:0]  op_a_s;
  logic [HN-1:0]  op_b_s;
  logic [MW-1:0]  prod_s;
  logic [MW-1:0]  z1_s;
  logic [2*W-1:0] mult1_s;
  logic [2*W-1:0] mult2_s;
  logic [2*W-1:0] mult3_s;
  logic           in_mul_s;
  logic           mul_done_s;

  assign in_mul_s = (state_r == ST_MUL_HI) || (state_r == ST_MUL_LO) ||
                    (state_r == ST_MUL_MID);

`ifdef KARA_MUL_PIPE_EN
  logic phase_r;
  logic phase_s;

  // Product for the current operands appears one cycle late, so each
  // multiply state finishes on its second cycle.
  assign mul_done_s = phase_r;
`else
  assign mul_done_s = 1'b1;
`endif

  // Shared multiplier operand select; the halves get a zero top bit.
  always_comb begin
    op_a_s = {HN{1'b0}};
    op_b_s = {HN{1'b0}};
    case (state_r)
      ST_MUL_HI: begin
        op_a_s = {1'b0, a_r[W-1:H]};
        op_b_s = {1'b0, b_r[W-1:H]};
      end
      ST_MUL_LO: begin
        op_a_s = {1'b0, a_r[H-1:0]};
        op_b_s = {1'b0, b_r[H-1:0]};
      end
      ST_MUL_MID: begin
        op_a_s = {1'b0, a_r[W-1:H]} + {1'b0, a_r[H-1:0]};
        op_b_s = {1'b0, b_r[W-1:H]} + {1'b0, b_r[H-1:0]};
      end
      default: begin
        op_a_s = {HN{1'b0}};
        op_b_s = {HN{1'b0}};
      end
    endcase
  end

  kara_half_mul #(
    .N (HN)
  ) u_half_mul (
`ifdef KARA_MUL_PIPE_EN
    .clk  (clk),
    .rst  (rst),
`endif
    .op_a (op_a_s),
    .op_b (op_b_s),
    .prod (prod_s)
  );

  // z1 = zm - z2 - z0 is always non-negative and below 2^(W+1).
  assign z1_s    = zm_r - {2'b00, z2_r} - {2'b00, z0_r};
  assign mult1_s = {z2_r, {W{1'b0}}};
  assign mult2_s = {{(2*W-MW){1'b0}}, z1_s} << H;
  assign mult3_s = {{W{1'b0}}, z0_r};

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

`ifdef KARA_MUL_PIPE_EN
  // Phase bit register for the two-cycle multiply states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r <= 1'b0;
    end else begin
      phase_r <= phase_s;
    end
  end
`endif

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
`ifdef KARA_MUL_PIPE_EN
    phase_s = 1'b0;
    if (in_mul_s) begin
      phase_s = ~phase_r;
    end else begin
      phase_s = 1'b0;
    end
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_s = ST_MUL_HI;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL_HI: begin
        if (mul_done_s) begin
          state_s = ST_MUL_LO;
        end else begin
          state_s = ST_MUL_HI;
        end
      end
      ST_MUL_LO: begin
        if (mul_done_s) begin
          state_s = ST_MUL_MID;
        end else begin
          state_s = ST_MUL_LO;
        end
      end
      ST_MUL_MID: begin
        if (mul_done_s) begin
          state_s = ST_FORM;
        end else begin
          state_s = ST_MUL_MID;
        end
      end
      ST_FORM: begin
        state_s = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Operand capture, sub-product registers and issued terms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r         <= {W{1'b0}};
      b_r         <= {W{1'b0}};
      z2_r        <= {W{1'b0}};
      z0_r        <= {W{1'b0}};
      zm_r        <= {MW{1'b0}};
      mult1_r     <= {(2*W){1'b0}};
      mult2_r     <= {(2*W){1'b0}};
      mult3_r     <= {(2*W){1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_r <= bus.a;
            b_r <= bus.b;
          end
        end
        ST_MUL_HI: begin
          // High two product bits are zero for half-width operands.
          if (mul_done_s) begin
            z2_r <= prod_s[W-1:0];
          end
        end
        ST_MUL_LO: begin
          if (mul_done_s) begin
            z0_r <= prod_s[W-1:0];
          end
        end
        ST_MUL_MID: begin
          if (mul_done_s) begin
            zm_r <= prod_s;
          end
        end
        ST_FORM: begin
          mult1_r     <= mult1_s;
          mult2_r     <= mult2_s;
          mult3_r     <= mult3_s;
          out_valid_r <= 1'b1;
        end
        ST_HOLD: begin
          // Terms are left in place after release.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == ST_IDLE);
  assign bus.busy      = (state_r != ST_IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.mult1     = mult1_r;
  assign bus.mult2     = mult2_r;
  assign bus.mult3     = mult3_r;

endmodule

// File: tb/tb_karatsuba_split_issue.sv
// tb_karatsuba_split_issue: self-checking bench for karatsuba_split_issue.
// Directed vectors with known terms, latency, back-pressure and reset
// mid-operation, then randomized traffic against a schoolbook reference
// (z1 = aH*bL + aL*bH). Honors KARA_MUL_PIPE_EN for the expected latency.
module tb_karatsuba_split_issue;
  import kara_pkg::*;

  localparam int W = 32;
`ifdef KARA_MUL_PIPE_EN
  localparam int LAT      = 7;
  localparam int LO_EDGES = 2;
`else
  localparam int LAT      = 4;
  localparam int LO_EDGES = 1;
`endif
  localparam int NRAND = 3000;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  karatsuba_split_issue_if #(.W(W)) bus ();

  karatsuba_split_issue #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Schoolbook form of the three aligned terms.
  function automatic void ref_terms(input logic [31:0] a, input logic [31:0] b,
                                    output logic [63:0] m1, output logic [63:0] m2,
                                    output logic [63:0] m3);
    longint unsigned ah, al, bh, bl;
    ah = longint'(a) >> 16;
    al = longint'(a) & 64'hFFFF;
    bh = longint'(b) >> 16;
    bl = longint'(b) & 64'hFFFF;
    m1 = (ah * bh) << 32;
    m2 = (ah * bl + al * bh) << 16;
    m3 = al * bl;
  endfunction

  task automatic check_terms(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] e1, input logic [63:0] e2, input logic [63:0] e3);
    logic [64:0] sum;
    logic [63:0] prod;
    sum  = {1'b0, bus.mult1} + {1'b0, bus.mult2} + {1'b0, bus.mult3};
    prod = 64'(a) * 64'(b);
    check_eq({tag, ".mult1"}, bus.mult1, e1);
    check_eq({tag, ".mult2"}, bus.mult2, e2);
    check_eq({tag, ".mult3"}, bus.mult3, e3);
    check_eq({tag, ".sum"}, sum, {1'b0, prod});
  endtask

  // Starts at a negedge; returns at a negedge with out_valid high (terms held).
  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] e1, input logic [63:0] e2, input logic [63:0] e3);
    int edges;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    #1;
    check_eq({tag, ".in_ready"}, bus.in_ready, 1'b1);
    @(posedge clk);
    edges = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (bus.out_valid !== 1'b1 && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check_eq({tag, ".latency"}, edges, LAT);
    check_terms(tag, a, b, e1, e2, e3);
  endtask

  // Accepts held terms; returns at a negedge.
  task automatic release_terms(input string tag, input logic [63:0] e1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq({tag, ".ov_clr"}, bus.out_valid, 1'b0);
    check_eq({tag, ".idle_rdy"}, bus.in_ready, 1'b1);
    check_eq({tag, ".idle_busy"}, bus.busy, 1'b0);
    check_eq({tag, ".mult1_keep"}, bus.mult1, e1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [63:0] e1, e2, e3;
    logic [31:0] ra, rb;
    logic [63:0] q[$];
    logic [63:0] ent;
    int acc_n, done_n;
    logic fire_in, fire_out;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst.in_ready", bus.in_ready, 1'b1);
    check_eq("rst.out_valid", bus.out_valid, 1'b0);
    check_eq("rst.busy", bus.busy, 1'b0);
    check_eq("rst.mult1", bus.mult1, 64'd0);
    check_eq("rst.mult2", bus.mult2, 64'd0);
    check_eq("rst.mult3", bus.mult3, 64'd0);

    // No capture without in_valid.
    bus.a = 32'h1234_5678;
    bus.b = 32'h9ABC_DEF0;
    repeat (3) @(negedge clk);
    check_eq("noval.busy", bus.busy, 1'b0);

    issue("v1", 32'h0001_0002, 32'h0003_0004,
          64'h0000_0003_0000_0000, 64'h0000_0000_000A_0000, 64'h8);
    release_terms("v1", 64'h0000_0003_0000_0000);

    // Reset in MUL_LO abandons the operation.
    bus.a        = 32'hCAFE_F00D;
    bus.b        = 32'h1357_9BDF;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (LO_EDGES) @(posedge clk);
    @(negedge clk);
    check_eq("mrst.busy_pre", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("mrst.in_ready", bus.in_ready, 1'b1);
    check_eq("mrst.out_valid", bus.out_valid, 1'b0);
    check_eq("mrst.busy", bus.busy, 1'b0);
    check_eq("mrst.mult1", bus.mult1, 64'd0);
    check_eq("mrst.mult2", bus.mult2, 64'd0);
    check_eq("mrst.mult3", bus.mult3, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    issue("v2", 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          64'hFFFE_0001_0000_0000, 64'h0001_FFFC_0002_0000, 64'hFFFE_0001);
    release_terms("v2", 64'hFFFE_0001_0000_0000);
    issue("v3", 32'h0, 32'hDEAD_BEEF, 64'h0, 64'h0, 64'h0);
    release_terms("v3", 64'h0);
    issue("v4", 32'h0000_FFFF, 32'hFFFF_0000, 64'h0, 64'hFFFE_0001_0000, 64'h0);
    release_terms("v4", 64'h0);

    // Back-pressure with new operands waiting.
    ref_terms(32'h8765_4321, 32'h0F0F_F0F0, e1, e2, e3);
    issue("bp1", 32'h8765_4321, 32'h0F0F_F0F0, e1, e2, e3);
    bus.a        = 32'h2468_ACE0;
    bus.b        = 32'hFEDC_BA98;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("bp.out_valid", bus.out_valid, 1'b1);
      check_eq("bp.in_ready", bus.in_ready, 1'b0);
      check_eq("bp.busy", bus.busy, 1'b1);
      check_terms("bp.hold", 32'h8765_4321, 32'h0F0F_F0F0, e1, e2, e3);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq("bp.ov_clr", bus.out_valid, 1'b0);
    ref_terms(32'h2468_ACE0, 32'hFEDC_BA98, e1, e2, e3);
    issue("bp2", 32'h2468_ACE0, 32'hFEDC_BA98, e1, e2, e3);
    release_terms("bp2", e1);

    // Randomized traffic with a transfer queue.
    acc_n  = 0;
    done_n = 0;
    for (int cyc = 0; cyc < 60000; cyc++) begin
      if (acc_n >= NRAND && q.size() == 0) break;
      if (acc_n < NRAND) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.a         = $urandom;
      bus.b         = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      fire_in  = bus.in_valid & bus.in_ready;
      fire_out = bus.out_valid & bus.out_ready;
      if (fire_out) begin
        if (q.size() == 0) begin
          check_eq("rnd.extra", 1'b1, 1'b0);
        end else begin
          ent = q.pop_front();
          ra  = ent[63:32];
          rb  = ent[31:0];
          ref_terms(ra, rb, e1, e2, e3);
          check_terms("rnd", ra, rb, e1, e2, e3);
          done_n++;
        end
      end
      if (fire_in) begin
        q.push_back({bus.a, bus.b});
        acc_n++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("rnd.accepted", acc_n, NRAND);
    check_eq("rnd.completed", done_n, NRAND);
    check_eq("rnd.pending", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
